// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions for the sequential binary-to-BCD converter:
// FSM state type, nibble constants and the leading-zero blanking function.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] ADD3_THRESH = 4'd5;
  localparam int MAX_DIGITS = 16;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
  function automatic bit digits_ok(input int width, input int digits);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < digits; k++) p = p * 10;
    return p > ((longint'(1) << width) - 1);
  endfunction

  // Digit i is enabled when it or any more significant digit is nonzero;
  // the units digit is always enabled so zero shows as "0".
  function automatic logic [MAX_DIGITS-1:0] digit_en_of(
      input logic [NIBBLE_W*MAX_DIGITS-1:0] bcd);
    logic [MAX_DIGITS-1:0] en;
    logic any_nz;
    en = '0;
    any_nz = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (bcd[NIBBLE_W*i +: NIBBLE_W] != '0);
      en[i] = any_nz;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a client and the binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     digit_en;

  modport master (output start, bin_in, input busy, done, bcd_out, digit_en);
  modport slave  (input start, bin_in, output busy, done, bcd_out, digit_en);
endinterface

// File: rtl/bin2bcd_seq_bcd_add3_cell.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3_cell
  import bin2bcd_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] d_in,
  output logic [NIBBLE_W-1:0] d_out
);
  // Inputs are always < 10 here, so the 4-bit sum never wraps.
  always_comb begin
    d_out = d_in;
    if (d_in >= ADD3_THRESH) d_out = d_in + 4'd3;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the seven-segment decoders with per-digit blanking enables.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (!digits_ok(WIDTH, DIGITS) || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH or above MAX_DIGITS");
  end

  state_t                  state_q, state_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0]       en_q, en_d;
  logic                    done_q, done_d;
  logic [BCD_W-1:0]        corr;
  logic [NIBBLE_W*MAX_DIGITS-1:0] bcd_ext;
  logic [MAX_DIGITS-1:0]   en_full;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .d_in  (sr_q[WIDTH + NIBBLE_W*g +: NIBBLE_W]),
      .d_out (corr[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  always_comb begin
    bcd_ext = '0;
    bcd_ext[BCD_W-1:0] = sr_q[SR_W-1:WIDTH];
    en_full = digit_en_of(bcd_ext);
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    en_d    = en_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{BCD_W{1'b0}}, bus.bin_in};
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Correct every nibble and shift in the same cycle.
        sr_d  = {corr[BCD_W-2:0], sr_q[WIDTH-1:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = sr_q[SR_W-1:WIDTH];
        en_d    = DIGITS'(en_full);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      en_q    <= DIGITS'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.digit_en = en_q;
endmodule
